// File: rtl/acs_pm_unit.sv
`default_nettype none
// ============================================================================
// Module      : acs_pm_unit
// Description : Add-compare-select and path-metric stage for a hard-decision
//               K=7, rate-1/2 Viterbi decoder. One trellis step per bm_valid;
//               emits per-state survivor decisions, best state and metric.
// Revision    : 1.0 - initial release
// ============================================================================
module acs_pm_unit #(
  parameter  int K       = 7,
  parameter  int PM_W    = 8,
  parameter  int INIT_PM = 64,
  localparam int NS      = 2**(K-1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bm_valid,
  input  logic [NS*4-1:0]   bm_bus,
  output logic              dec_valid,
  output logic [NS-1:0]     dec_bits,
  output logic [K-2:0]      best_state,
  output logic [PM_W-1:0]   best_pm,
  output logic              norm_flag
);

  localparam int              SW       = K - 1;
  localparam logic [PM_W-1:0] INIT_VAL = INIT_PM[PM_W-1:0];

  // Stored metrics and registered outputs
  logic [PM_W-1:0] pm_q [NS];
  logic [PM_W-1:0] pm_d [NS];
  logic            dec_valid_q, dec_valid_d;
  logic [NS-1:0]   dec_bits_q, dec_bits_d;
  logic [SW-1:0]   best_state_q, best_state_d;
  logic [PM_W-1:0] best_pm_q, best_pm_d;
  logic            norm_flag_q, norm_flag_d;

  // Step datapath
  logic [PM_W-1:0] pm_src   [NS];
  logic [PM_W-1:0] new_pm   [NS];
  logic [PM_W-1:0] new_norm [NS];
  logic [NS-1:0]   dec_w;
  logic [NS-1:0]   msb_w;
  logic            all_msb;
  logic [SW-1:0]   min_idx;
  logic [PM_W-1:0] min_val;

  // Metric source: a frame start restarts from the reset-initial metrics
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (start) begin
        pm_src[s] = (s == 0) ? '0 : INIT_VAL;
      end else begin
        pm_src[s] = pm_q[s];
      end
    end
  end

  // One ACS butterfly half per next state; predecessors share ns[K-3:0]
  for (genvar ns = 0; ns < NS; ns++) begin : g_acs
    localparam int P0 = (ns % (NS/2)) * 2;
    localparam int P1 = P0 + 1;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    assign c0         = pm_src[P0] + {{(PM_W-2){1'b0}}, bm_bus[ns*4 +: 2]};
    assign c1         = pm_src[P1] + {{(PM_W-2){1'b0}}, bm_bus[ns*4+2 +: 2]};
    assign dec_w[ns]  = (c1 < c0);
    assign new_pm[ns] = dec_w[ns] ? c1 : c0;
    assign msb_w[ns]  = new_pm[ns][PM_W-1];
  end

  assign all_msb = &msb_w;

  // Normalise by dropping the common MSB once every metric has crossed it
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      new_norm[s] = all_msb ? {1'b0, new_pm[s][PM_W-2:0]} : new_pm[s];
    end
  end

  // Argmin over normalised metrics; strict compare keeps the lowest index on ties
  always_comb begin
    min_idx = '0;
    min_val = new_norm[0];
    for (int s = 1; s < NS; s++) begin
      if (new_norm[s] < min_val) begin
        min_val = new_norm[s];
        min_idx = SW'(s);
      end
    end
  end

  // Next-state selection: advance on a valid step, otherwise hold
  always_comb begin
    pm_d          = pm_q;
    dec_bits_d    = dec_bits_q;
    best_state_d  = best_state_q;
    best_pm_d     = best_pm_q;
    norm_flag_d   = norm_flag_q;
    dec_valid_d   = 1'b0;
    if (bm_valid) begin
      pm_d         = new_norm;
      dec_bits_d   = dec_w;
      best_state_d = min_idx;
      best_pm_d    = min_val;
      norm_flag_d  = all_msb;
      dec_valid_d  = 1'b1;
    end
  end

  // State registers; reset overrides any step sampled on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        pm_q[s] <= (s == 0) ? '0 : INIT_VAL;
      end
      dec_valid_q  <= 1'b0;
      dec_bits_q   <= '0;
      best_state_q <= '0;
      best_pm_q    <= '0;
      norm_flag_q  <= 1'b0;
    end else begin
      pm_q         <= pm_d;
      dec_valid_q  <= dec_valid_d;
      dec_bits_q   <= dec_bits_d;
      best_state_q <= best_state_d;
      best_pm_q    <= best_pm_d;
      norm_flag_q  <= norm_flag_d;
    end
  end

  assign dec_valid  = dec_valid_q;
  assign dec_bits   = dec_bits_q;
  assign best_state = best_state_q;
  assign best_pm    = best_pm_q;
  assign norm_flag  = norm_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_acs_pm_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_acs_pm_unit
// Description : Directed self-checking bench for acs_pm_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acs_pm_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         bm_valid;
  logic [255:0] bm_bus;
  logic         dec_valid;
  logic [63:0]  dec_bits;
  logic [5:0]   best_state;
  logic [7:0]   best_pm;
  logic         norm_flag;

  int n_vec = 0;
  int n_err = 0;

  acs_pm_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bm_valid   (bm_valid),
    .bm_bus     (bm_bus),
    .dec_valid  (dec_valid),
    .dec_bits   (dec_bits),
    .best_state (best_state),
    .best_pm    (best_pm),
    .norm_flag  (norm_flag)
  );

  always #5 clk = ~clk;

  // Every next state gets path_0 = b0, path_1 = b1
  function automatic logic [255:0] bm_fill(input logic [1:0] b0, input logic [1:0] b1);
    logic [255:0] v;
    for (int i = 0; i < 64; i++) begin
      v[i*4 +: 2]   = b0;
      v[i*4+2 +: 2] = b1;
    end
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bm_valid = 1'b0; start = 1'b0; bm_bus = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one step on a negedge; outputs are sampled at the following negedge
  task automatic one_step(input logic s, input logic [255:0] b);
    @(negedge clk);
    bm_valid = 1'b1; start = s; bm_bus = b;
    @(negedge clk);
    bm_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_dec_valid cyc%0d got %b want 0", i, dec_valid); end
    end
    n_vec++; if (best_state !== 6'd0) begin n_err++; $display("FAIL reset_best_state got %0d want 0", best_state); end
    n_vec++; if (best_pm !== 8'd0) begin n_err++; $display("FAIL reset_best_pm got %0d want 0", best_pm); end
    n_vec++; if (dut.pm_q[0] !== 8'd0) begin n_err++; $display("FAIL reset_pm0 got %0d want 0", dut.pm_q[0]); end
    n_vec++; if (dut.pm_q[63] !== 8'd64) begin n_err++; $display("FAIL reset_pm63 got %0d want 64", dut.pm_q[63]); end
  endtask

  // Zero-metric step from the initial metrics; shared by several scenarios
  task automatic test_zero_step(input string tag, input logic s);
    one_step(s, '0);
    n_vec++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL %s_dec_valid got %b want 1", tag, dec_valid); end
    n_vec++; if (dec_bits !== 64'h0) begin n_err++; $display("FAIL %s_dec_bits got %h want 0", tag, dec_bits); end
    n_vec++; if (best_state !== 6'd0) begin n_err++; $display("FAIL %s_best_state got %0d want 0", tag, best_state); end
    n_vec++; if (best_pm !== 8'd0) begin n_err++; $display("FAIL %s_best_pm got %0d want 0", tag, best_pm); end
    n_vec++; if (norm_flag !== 1'b0) begin n_err++; $display("FAIL %s_norm_flag got %b want 0", tag, norm_flag); end
    n_vec++; if (dut.pm_q[63] !== 8'd64) begin n_err++; $display("FAIL %s_pm63 got %0d want 64", tag, dut.pm_q[63]); end
    @(negedge clk);
    n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL %s_pulse got %b want 0", tag, dec_valid); end
  endtask

  // path_0 cost 1, path_1 cost 0: only ns 0 and 32 keep p0 (pm 0 + 1 < 64)
  task automatic test_dec_direction();
    do_reset();
    one_step(1'b0, bm_fill(2'b01, 2'b00));
    n_vec++; if (dec_bits !== 64'hFFFF_FFFE_FFFF_FFFE) begin n_err++; $display("FAIL dir_dec_bits got %h want fffffffefffffffe", dec_bits); end
    n_vec++; if (best_pm !== 8'd1) begin n_err++; $display("FAIL dir_best_pm got %0d want 1", best_pm); end
    n_vec++; if (dut.pm_q[5] !== 8'd64) begin n_err++; $display("FAIL dir_pm5 got %0d want 64", dut.pm_q[5]); end
  endtask

  // ns=32 gets the cheapest path; then tie ns=0 with it to check lowest index
  task automatic test_best_state();
    logic [255:0] b;
    do_reset();
    b = bm_fill(2'b11, 2'b11);
    b[32*4 +: 2] = 2'b01;
    one_step(1'b0, b);
    n_vec++; if (best_state !== 6'd32) begin n_err++; $display("FAIL best_state_32 got %0d want 32", best_state); end
    n_vec++; if (best_pm !== 8'd1) begin n_err++; $display("FAIL best_pm_32 got %0d want 1", best_pm); end
    do_reset();
    b[0 +: 2] = 2'b01;
    one_step(1'b0, b);
    n_vec++; if (best_state !== 6'd0) begin n_err++; $display("FAIL best_tie got %0d want 0", best_state); end
    n_vec++; if (best_pm !== 8'd1) begin n_err++; $display("FAIL best_tie_pm got %0d want 1", best_pm); end
  endtask

  task automatic test_single_penalty();
    logic [255:0] b;
    do_reset();
    repeat (6) one_step(1'b0, '0);
    n_vec++; if (dut.pm_q[63] !== 8'd0) begin n_err++; $display("FAIL pen_pm63 got %0d want 0", dut.pm_q[63]); end
    b = '0;
    b[5*4 +: 2] = 2'b10;
    one_step(1'b0, b);
    n_vec++; if (dec_bits !== 64'h20) begin n_err++; $display("FAIL pen_dec_bits got %h want 20", dec_bits); end
    n_vec++; if (best_state !== 6'd0) begin n_err++; $display("FAIL pen_best_state got %0d want 0", best_state); end
    n_vec++; if (best_pm !== 8'd0) begin n_err++; $display("FAIL pen_best_pm got %0d want 0", best_pm); end
  endtask

  // 64 back-to-back steps of cost 2: metrics climb 2 per step and wrap at 128
  task automatic test_back_to_back_norm();
    do_reset();
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i > 1) begin
        n_vec++; if (dec_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid step%0d got %b want 1", i-1, dec_valid); end
        n_vec++; if (norm_flag !== 1'b0) begin n_err++; $display("FAIL b2b_norm step%0d got %b want 0", i-1, norm_flag); end
        n_vec++; if (best_pm !== 8'(2*(i-1))) begin n_err++; $display("FAIL b2b_best_pm step%0d got %0d want %0d", i-1, best_pm, 2*(i-1)); end
      end
      bm_valid = 1'b1; start = 1'b0; bm_bus = bm_fill(2'b10, 2'b10);
    end
    @(negedge clk);
    bm_valid = 1'b0;
    n_vec++; if (norm_flag !== 1'b1) begin n_err++; $display("FAIL norm_flag64 got %b want 1", norm_flag); end
    n_vec++; if (best_pm !== 8'd0) begin n_err++; $display("FAIL norm_best_pm got %0d want 0", best_pm); end
    n_vec++; if (best_state !== 6'd0) begin n_err++; $display("FAIL norm_best_state got %0d want 0", best_state); end
    n_vec++; if (dut.pm_q[63] !== 8'd0) begin n_err++; $display("FAIL norm_pm63 got %0d want 0", dut.pm_q[63]); end
  endtask

  // Frame restart mid-stream, then a start without bm_valid must be ignored
  task automatic test_start();
    one_step(1'b0, bm_fill(2'b11, 2'b11));
    n_vec++; if (best_pm !== 8'd3) begin n_err++; $display("FAIL pre_start_pm got %0d want 3", best_pm); end
    test_zero_step("start", 1'b1);
    @(negedge clk);
    start = 1'b1; bm_valid = 1'b0; bm_bus = bm_fill(2'b11, 2'b11);
    @(negedge clk);
    start = 1'b0;
    n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL idle_start_valid got %b want 0", dec_valid); end
    n_vec++; if (dut.pm_q[32] !== 8'd0) begin n_err++; $display("FAIL idle_start_pm32 got %0d want 0", dut.pm_q[32]); end
    n_vec++; if (dut.pm_q[63] !== 8'd64) begin n_err++; $display("FAIL idle_start_pm63 got %0d want 64", dut.pm_q[63]); end
  endtask

  // Reset on the same edge a step is sampled discards the step
  task automatic test_reset_midstep();
    do_reset();
    repeat (2) one_step(1'b0, bm_fill(2'b11, 2'b11));
    @(negedge clk);
    rst_n = 1'b0; bm_valid = 1'b1; bm_bus = bm_fill(2'b01, 2'b01);
    @(negedge clk);
    rst_n = 1'b1; bm_valid = 1'b0;
    n_vec++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", dec_valid); end
    n_vec++; if (best_pm !== 8'd0) begin n_err++; $display("FAIL rstmid_best_pm got %0d want 0", best_pm); end
    n_vec++; if (dut.pm_q[0] !== 8'd0) begin n_err++; $display("FAIL rstmid_pm0 got %0d want 0", dut.pm_q[0]); end
    n_vec++; if (dut.pm_q[63] !== 8'd64) begin n_err++; $display("FAIL rstmid_pm63 got %0d want 64", dut.pm_q[63]); end
    test_zero_step("after_rst", 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bm_valid = 1'b0; bm_bus = '0;
    test_reset();
    test_zero_step("first", 1'b0);
    test_dec_direction();
    test_best_state();
    test_single_penalty();
    test_back_to_back_norm();
    test_start();
    test_reset_midstep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
